mac_seq: RTL and testbench

MAC_SEQ -- requirements
Module: mac_seq

---
 rtl/mac_seq.sv | 132 +++++++++++++
 tb/tb_mac_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// Sequential multiply-accumulate over two coefficient memories (A, B).
// Optional macro MAC_SAT_EN: saturating accumulator with sticky ovf; otherwise wrap and ovf=0.
module mac_seq #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic             start,
    input  logic [AW:0]      len,
    input  logic             sgn,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t state, nxt;

    logic [DW-1:0]    mem_a [DEPTH];
    logic [DW-1:0]    mem_b [DEPTH];
    logic [AW:0]      len_c, len_r, idx;
    logic             sgn_r, op_vld;
    logic [DW-1:0]    op_a, op_b;
    logic [2*DW-1:0]  ax, bx, prod;
    logic [ACC_W-1:0] prod_x, acc, acc_nxt;

    assign len_c  = (len > DEPTH_L) ? DEPTH_L : len;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign result = acc;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = (len_c == '0) ? DONE : RUN;
            RUN:     if (idx == len_r - 1'b1) nxt = DRAIN;
            DRAIN:   nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Memories carry no reset so contents survive an aborted run.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE) begin
            if (wr_sel) mem_b[wr_addr] <= wr_data;
            else        mem_a[wr_addr] <= wr_data;
        end
    end

    // Operands are extended to 2*DW before the multiply so one multiplier serves both modes.
    always_comb begin
        ax     = sgn_r ? {{DW{op_a[DW-1]}}, op_a} : {{DW{1'b0}}, op_a};
        bx     = sgn_r ? {{DW{op_b[DW-1]}}, op_b} : {{DW{1'b0}}, op_b};
        prod   = ax * bx;
        prod_x = sgn_r ? ACC_W'($signed(prod)) : ACC_W'(prod);
    end

`ifdef MAC_SAT_EN
    logic [ACC_W:0] sum;
    logic           of;
    logic           ovf_r;

    always_comb begin
        if (sgn_r) begin
            sum = {acc[ACC_W-1], acc} + {prod_x[ACC_W-1], prod_x};
            of  = sum[ACC_W] ^ sum[ACC_W-1];
        end else begin
            sum = {1'b0, acc} + {1'b0, prod_x};
            of  = sum[ACC_W];
        end
        acc_nxt = sum[ACC_W-1:0];
        if (of) acc_nxt = sgn_r ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : '1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                    ovf_r <= 1'b0;
        else if (state == IDLE && start) ovf_r <= 1'b0;
        else if (op_vld && of)         ovf_r <= 1'b1;
    end

    assign ovf = ovf_r;
`else
    assign acc_nxt = acc + prod_x;
    assign ovf     = 1'b0;
`endif

    // Pair idx registers at the end of each RUN cycle; its product lands one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_r  <= '0;
            sgn_r  <= 1'b0;
            idx    <= '0;
            op_vld <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
        end else begin
            op_vld <= (state == RUN);
            if (state == RUN) begin
                op_a <= mem_a[idx[AW-1:0]];
                op_b <= mem_b[idx[AW-1:0]];
                idx  <= idx + 1'b1;
            end
            if (state == IDLE && start) begin
                len_r <= len_c;
                sgn_r <= sgn;
                idx   <= '0;
                acc   <= '0;
            end else if (op_vld) begin
                acc <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: vector table, corner sequences and randomized runs
// against an arithmetic reference model (honours MAC_SAT_EN).
module tb_mac_seq;
    localparam int DW = 8, DEPTH = 16, AW = 4;

    logic clk = 0, rst_n = 0, wr_en = 0, wr_sel = 0, start = 0, sgn = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, ovf, busy16, done16, ovf16;
    logic [19:0]   result;
    logic [15:0]   result16;

    logic [DW-1:0] ma [DEPTH];
    logic [DW-1:0] mb [DEPTH];
    int ntot = 0, npass = 0;

    typedef struct {
        int     mode;  // 1: A[i]=i+1, 0: A constant
        int     av;
        int     bv;
        int     l;
        bit     s;
        longint exp;
    } vec_t;
    vec_t tbl [7];

    mac_seq #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .ACC_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .len(len), .sgn(sgn),
        .busy(busy), .done(done), .result(result), .ovf(ovf));

    mac_seq #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .ACC_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .len(len), .sgn(sgn),
        .busy(busy16), .done(done16), .result(result16), .ovf(ovf16));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference: sum of A[i]*B[i] as plain integers, clamped per term when saturating.
    task automatic model(input int l, input bit s, input int aw, output longint r, output bit o);
        longint acc, a, b, mx, mn;
        int lc;
        lc  = (l > DEPTH) ? DEPTH : l;
        acc = 0;
        o   = 0;
        mx  = s ? (64'sd1 <<< (aw-1)) - 1 : (64'sd1 <<< aw) - 1;
        mn  = s ? -(64'sd1 <<< (aw-1)) : 0;
        for (int i = 0; i < lc; i++) begin
            a = s ? longint'($signed(ma[i])) : longint'(ma[i]);
            b = s ? longint'($signed(mb[i])) : longint'(mb[i]);
            acc += a * b;
`ifdef MAC_SAT_EN
            if (acc > mx) begin acc = mx; o = 1; end
            if (acc < mn) begin acc = mn; o = 1; end
`endif
        end
        r = acc & ((64'sd1 <<< aw) - 1);
    endtask

    task automatic wr(input bit s, input int a, input int d);
        wr_en = 1; wr_sel = s; wr_addr = AW'(a); wr_data = DW'(d);
        @(posedge clk); @(negedge clk);
        wr_en = 0;
        if (s) mb[a] = DW'(d); else ma[a] = DW'(d);
    endtask

    task automatic fill(input int mode, input int av, input int bv);
        for (int i = 0; i < DEPTH; i++) begin
            wr(0, i, mode ? i + 1 : av);
            wr(1, i, bv);
        end
    endtask

    // Cycle 1 is the cycle after the accepting edge; returns the cycle where done is seen.
    task automatic run(input int l, input bit s, input int inj, input bit bw, output int dcyc);
        start = 1; len = (AW+1)'(l); sgn = s;
        @(posedge clk); @(negedge clk);
        start = 0; wr_en = 0;
        dcyc = -1;
        for (int c = 1; c <= 40; c++) begin
            start = (inj == c);
            if (start) len = 1;
            wr_en = bw && (c == 2);
            if (wr_en) begin wr_sel = 0; wr_addr = '0; wr_data = 8'h77; end
            if (done) begin dcyc = c; break; end
            @(negedge clk);
        end
        start = 0; wr_en = 0;
    endtask

    task automatic go(input string nm, input int l, input bit s, input int inj,
                      input bit bw, input bit c16);
        int dc, lc;
        longint r, r16;
        bit o, o16;
        lc = (l > DEPTH) ? DEPTH : l;
        run(l, s, inj, bw, dc);
        chk({nm, "_lat"}, dc, (lc == 0) ? 1 : lc + 2);
        model(l, s, 20, r, o);
        chk({nm, "_res"}, result, r);
        chk({nm, "_ovf"}, ovf, o);
        chk({nm, "_busy"}, busy, 1);
        if (c16) begin
            model(l, s, 16, r16, o16);
            chk({nm, "_res16"}, result16, r16);
            chk({nm, "_ovf16"}, ovf16, o16);
            chk({nm, "_done16"}, done16, 1);
            chk({nm, "_busy16"}, busy16, 1);
        end
        @(negedge clk);
        chk({nm, "_done_pulse"}, done, 0);
        chk({nm, "_idle"}, busy, 0);
        chk({nm, "_hold"}, result, r);
    endtask

    initial begin
        int nd;
        tbl[0] = '{1, 0,    2,    16, 0, 272};
        tbl[1] = '{0, 8'h80, 8'h7F, 4, 1, 64'hF0200};
        tbl[2] = '{0, 3,    5,     0, 0, 0};
        tbl[3] = '{0, 8'hFF, 8'hFF, 1, 1, 1};
        tbl[4] = '{0, 8'hFF, 8'hFF, 16, 0, 1040400};
        tbl[5] = '{0, 1,    1,    20, 0, 16};
        tbl[6] = '{0, 8'h80, 8'h80, 16, 1, 262144};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            fill(tbl[i].mode, tbl[i].av, tbl[i].bv);
            go($sformatf("vec%0d", i), tbl[i].l, tbl[i].s, 0, 0, 0);
            chk($sformatf("vec%0d_const", i), result, tbl[i].exp);
        end

        // start pulses during RUN must not disturb timing or result
        fill(1, 0, 2);
        go("inj", 16, 0, 3, 0, 0);
        chk("inj_const", result, 272);

        // reset in RUN cycle 5: silent abort, memories kept
        start = 1; len = 16; sgn = 0;
        @(posedge clk); @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        rst_n = 0;
        @(posedge clk); @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_ovf", ovf, 0);
        rst_n = 1;
        nd = 0;
        repeat (20) begin @(negedge clk); if (done) nd++; end
        chk("abort_no_done", nd, 0);
        go("rerun", 16, 0, 0, 0, 0);
        chk("rerun_const", result, 272);

        // write and start in the same cycle: run sees the new value
        wr_en = 1; wr_sel = 0; wr_addr = '0; wr_data = 8'd9; ma[0] = 8'd9;
        go("wrstart", 1, 0, 0, 0, 0);
        chk("wrstart_const", result, 18);

        // write while busy is dropped (model memory left untouched)
        go("bw", 16, 0, 0, 1, 0);
        go("bw_after", 16, 0, 0, 0, 0);

        // narrow accumulator overflow
        wr(0, 0, 255); wr(0, 1, 255); wr(1, 0, 255); wr(1, 1, 255);
        go("ovfu", 2, 0, 0, 0, 1);
`ifdef MAC_SAT_EN
        chk("ovfu_const16", result16, 65535);
        chk("ovfu_constovf", ovf16, 1);
`else
        chk("ovfu_const16", result16, 64514);
        chk("ovfu_constovf", ovf16, 0);
`endif
        wr(0, 0, 8'h80); wr(0, 1, 8'h80); wr(1, 0, 8'h80); wr(1, 1, 8'h80);
        go("ovfs", 2, 1, 0, 0, 1);

        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                wr(0, i, int'($urandom_range(0, 255)));
                wr(1, i, int'($urandom_range(0, 255)));
            end
            go($sformatf("rnd%0d", k), int'($urandom_range(0, 20)), 1'($urandom), 0, 0, 1);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
